// File: rtl/sqrt_sched.sv
// Shared Q24.8 bisection square-root engine with round-robin arbitration across NUM_REQ requesters.
// Optional macro SQRT_SCHED_PERF_EN adds perf_ops/perf_busy counter ports.
//
// state  | meaning
// S_IDLE | waiting for a request; req_ready driven by the arbiter
// S_RUN  | one bisection iteration per clock
// S_DONE | holding result until resp_ready
module sqrt_sched #(
  parameter int NUM_REQ = 4,
  parameter int ITERS   = 32,
  parameter int IDW     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_root,
  output logic [IDW-1:0]        resp_id,
  output logic                  busy
`ifdef SQRT_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_ops,
  output logic [31:0]           perf_busy
`endif
);

  localparam int ITW = $clog2(ITERS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_low;
  logic [31:0]      r_high;
  logic [31:0]      r_x;
  logic [31:0]      r_root;
  logic [ITW-1:0]   r_iter;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_rr_last;

  logic [32:0]      w_sum;
  logic [31:0]      w_mid;
  logic [63:0]      w_prod;
  logic [31:0]      w_mid_sq;
  logic             w_exact;
  logic             w_last_iter;
  logic             w_found;
  logic [IDW-1:0]   w_gnt;
  logic [IDW-1:0]   w_idx;
  logic [31:0]      w_gnt_data;
  logic             w_accept;
  logic             w_unused;

  assign w_sum       = {1'b0, r_low} + {1'b0, r_high};
  assign w_mid       = w_sum[32:1];
  assign w_prod      = {32'b0, w_mid} * {32'b0, w_mid};
  assign w_mid_sq    = w_prod[39:8];
  assign w_exact     = (w_mid_sq == r_x);
  assign w_last_iter = (r_iter == ITW'(ITERS - 1));
  assign w_unused    = ^{w_sum[0], w_prod[63:40], w_prod[7:0]};
  assign w_gnt_data  = req_data[{w_gnt, 5'b0} +: 32];

  // first valid requester scanning upward from rr_last+1 with wrap
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = IDW'((int'(r_rr_last) + i) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          req_ready[w_gnt] = 1'b1;
          w_accept         = 1'b1;
          w_state_nxt      = S_RUN;
        end
      end
      S_RUN:   if (w_exact || w_last_iter) w_state_nxt = S_DONE;
      S_DONE:  if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_low     <= '0;
      r_high    <= '0;
      r_x       <= '0;
      r_root    <= '0;
      r_iter    <= '0;
      r_id      <= '0;
      r_rr_last <= IDW'(NUM_REQ - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_low     <= '0;
            r_high    <= w_gnt_data;
            r_x       <= w_gnt_data;
            r_id      <= w_gnt;
            r_iter    <= '0;
            r_rr_last <= w_gnt;
          end
        end
        S_RUN: begin
          r_iter <= r_iter + 1'b1;
          // on the final non-matching iteration the last mid is the answer
          if (w_exact || w_last_iter) r_root <= w_mid;
          else if (w_mid_sq < r_x)    r_low  <= w_mid;
          else                        r_high <= w_mid;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (r_state == S_DONE);
  assign resp_root  = r_root;
  assign resp_id    = r_id;
  assign busy       = (r_state != S_IDLE);

`ifdef SQRT_SCHED_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_ops  <= '0;
      r_perf_busy <= '0;
    end else begin
      if (resp_valid && resp_ready) r_perf_ops <= r_perf_ops + 32'd1;
      if (busy)                     r_perf_busy <= r_perf_busy + 32'd1;
    end
  end

  assign perf_ops  = r_perf_ops;
  assign perf_busy = r_perf_busy;
`endif

endmodule

// File: tb/tb_sqrt_sched.sv
// Self-checking bench for sqrt_sched: vector table, scoreboard of expected responses, and
// hand-written sequences for arbitration, backpressure and mid-operation reset.
module tb_sqrt_sched;
  localparam int NUM_REQ = 4;
  localparam int ITERS   = 32;
  localparam int IDW     = 2;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_root;
  logic [IDW-1:0]        resp_id;
  logic                  busy;
`ifdef SQRT_SCHED_PERF_EN
  logic [31:0]           perf_ops;
  logic [31:0]           perf_busy;
`endif

  sqrt_sched #(.NUM_REQ(NUM_REQ), .ITERS(ITERS), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_root  (resp_root),
    .resp_id    (resp_id),
    .busy       (busy)
`ifdef SQRT_SCHED_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_busy  (perf_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    root;
  } exp_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [31:0] root;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   grants[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic fail_timeout(input string nm);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Reference bisection: exact-match exit or ITERS iterations, root = last mid.
  function automatic void model(input logic [31:0] x, output logic [31:0] root, output int n);
    logic [31:0] lo, hi, mid, sq;
    logic [32:0] s;
    logic [63:0] p;
    lo = 0; hi = x; root = 0; n = 0;
    for (int k = 1; k <= ITERS; k++) begin
      s    = {1'b0, lo} + {1'b0, hi};
      mid  = s[32:1];
      p    = {32'b0, mid} * {32'b0, mid};
      sq   = p[39:8];
      n    = k;
      root = mid;
      if (sq == x) return;
      if (sq < x) lo = mid;
      else        hi = mid;
    end
  endfunction

  logic [31:0] mon_root;
  int          mon_n;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < NUM_REQ; g++) begin
        if (req_valid[g] && req_ready[g]) begin
          model(req_data[32*g +: 32], mon_root, mon_n);
          sb.push_back('{id: IDW'(g), root: mon_root});
          grants.push_back(g);
        end
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got response id %0d root %0h, expected none", resp_id, resp_root);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_root", 64'(resp_root), 64'(mon_e.root));
          chk("sb_id", 64'(resp_id), 64'(mon_e.id));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    if (busy) fail_timeout(nm);
  endtask

  task automatic do_op(input int id, input logic [31:0] d, input int lat,
                       input bit use_root, input logic [31:0] er);
    int t, k;
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_data[32*id +: 32] = d;
    #1;
    k = 0;
    while (!req_ready[id] && k < 50) begin @(negedge clk); #1; k++; end
    if (!req_ready[id]) begin
      fail_timeout("grant");
      req_valid[id] = 1'b0;
      return;
    end
    t = cyc;
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    k = 0;
    while (!resp_valid && k < 100) begin @(negedge clk); k++; end
    if (!resp_valid) begin fail_timeout("resp"); return; end
    chk("latency", 64'(cyc - t), 64'(lat));
    if (use_root) chk("root", 64'(resp_root), 64'(er));
    @(negedge clk);
    wait_idle("op_idle");
  endtask

  vec_t vecs[5];

  initial begin
    int t, k, bad, seen, n;
    logic [31:0] r, d;
    rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b1;

    vecs[0] = '{id: 0, data: 32'h0000_0400, root: 32'h0000_0200, lat: 2};
    vecs[1] = '{id: 1, data: 32'h0000_0900, root: 32'h0000_0300, lat: 12};
    vecs[2] = '{id: 3, data: 32'h0000_0000, root: 32'h0000_0000, lat: 2};
    vecs[3] = '{id: 0, data: 32'h0001_0000, root: 32'h0000_1000, lat: 5};
    vecs[4] = '{id: 2, data: 32'h0000_0200, root: 32'h0000_016A, lat: 33};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_root", 64'(resp_root), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);

    // full-length non-exact operation straight out of reset
    do_op(2, 32'h0000_0200, 33, 1'b1, 32'h0000_016A);
`ifdef SQRT_SCHED_PERF_EN
    chk("perf_ops", 64'(perf_ops), 64'd1);
    chk("perf_busy", 64'(perf_busy), 64'd33);
`endif

    for (int i = 0; i < 5; i++)
      do_op(vecs[i].id, vecs[i].data, vecs[i].lat, 1'b1, vecs[i].root);

    // round-robin with every requester held valid
    do_reset();
    grants.delete();
    @(negedge clk);
    req_data = {32'h0001_0000, 32'h0000_0000, 32'h0000_0900, 32'h0000_0400};
    req_valid = '1;
    k = 0;
    while (grants.size() < 5 && k < 500) begin @(posedge clk); #1; k++; end
    req_valid = '0;
    if (grants.size() < 5) fail_timeout("rr_grants");
    else
      for (int i = 0; i < 5; i++) chk($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(i % 4));
    @(negedge clk);
    wait_idle("rr_idle");
    chk("rr_sb_empty", 64'(sb.size()), 64'd0);

    // backpressure: result held while another requester waits
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid[0] = 1'b1; req_data[31:0] = 32'h0000_0900;
    #1;
    k = 0;
    while (!req_ready[0] && k < 50) begin @(negedge clk); #1; k++; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_valid[2] = 1'b1; req_data[95:64] = 32'h0000_0400;
    k = 0;
    while (!resp_valid && k < 100) begin @(negedge clk); k++; end
    if (!resp_valid) fail_timeout("bp_resp");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid !== 1'b1 || resp_root !== 32'h0000_0300 || resp_id !== 2'd0 || req_ready !== 4'b0000)
        bad++;
      @(negedge clk);
    end
    chk("bp_stable", 64'(bad), 64'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_grant", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    wait_idle("bp_idle");
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // reset during iteration 5
    @(negedge clk);
    req_valid[1] = 1'b1; req_data[63:32] = 32'h0000_0900;
    #1;
    k = 0;
    while (!req_ready[1] && k < 50) begin @(negedge clk); #1; k++; end
    t = cyc;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    k = 0;
    while (cyc < t + 5 && k < 50) begin @(negedge clk); k++; end
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_root", 64'(resp_root), 64'd0);
    chk("mid_rst_id", 64'(resp_id), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("mid_no_resp", 64'(seen), 64'd0);
    do_op(2, 32'h0000_0400, 2, 1'b1, 32'h0000_0200);

    // small operands and a random sweep against the model
    d = 32'h0000_0080;
    model(d, r, n);
    do_op(1, d, n + 1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      d = (i % 2 == 1) ? $urandom : $urandom_range(0, 4095);
      model(d, r, n);
      do_op(i % 4, d, n + 1, 1'b0, 32'h0);
    end
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
